// File: rtl/pair_sum_pkg.sv
// ============================================================================
//  Module      : pair_sum_pkg
//  Description : Shared constants and FSM state type for the pair-sum initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pair_sum_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        GET0  = 3'd0,
        GET1  = 3'd1,
        ISSUE = 3'd2,
        CAPT  = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage : pair_sum_pkg

`default_nettype wire

// File: rtl/pair_sum_initiator_if.sv
// ============================================================================
//  Module      : pair_sum_initiator_if
//  Description : Byte stream in, adder operand/sum link, result stream out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pair_sum_initiator_if
    import pair_sum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] op0;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] sum_in;
    logic [DATA_W-1:0] res_data;
    logic              res_last;
    logic              res_valid;
    logic              res_ready;

    // master: the initiator block itself
    modport master (
        input  in_data, in_valid, in_last, sum_in, res_ready,
        output in_ready, op0, op1, res_data, res_last, res_valid
    );

    // slave: producer, adder and consumer around the initiator
    modport slave (
        output in_data, in_valid, in_last, sum_in, res_ready,
        input  in_ready, op0, op1, res_data, res_last, res_valid
    );

endinterface : pair_sum_initiator_if

`default_nettype wire

// File: rtl/pair_sum_adder.sv
// ============================================================================
//  Module      : pair_sum_adder
//  Description : External registered adder (out <= in0 + in1, carry dropped).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pair_sum_adder
    import pair_sum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic [DATA_W-1:0] in0,
    input  wire logic [DATA_W-1:0] in1,
    output logic      [DATA_W-1:0] out
);

    always_ff @(posedge clock) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= in0 + in1;
        end
    end

endmodule : pair_sum_adder

`default_nettype wire

// File: rtl/pair_sum_initiator.sv
// ============================================================================
//  Module      : pair_sum_initiator
//  Description : Pairs stream bytes onto an external registered adder and
//                returns each sum as a back-pressured result stream.
//                Optional pair counter: define PAIR_SUM_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pair_sum_initiator
    import pair_sum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
`ifdef PAIR_SUM_STATS_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  wire logic              clock,
    input  wire logic              reset,
    pair_sum_initiator_if.master   bus
`ifdef PAIR_SUM_STATS_EN
    , output logic [CNT_W-1:0]     pair_cnt
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_res_hs;
    logic [DATA_W-1:0] r_op0;
    logic [DATA_W-1:0] r_op1;
    logic              r_last_flag;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_last;
    logic              r_res_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= GET0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            GET0: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    // An odd tail byte skips GET1 and is paired with zero.
                    w_state_nxt = bus.in_last ? ISSUE : GET1;
                end
            end
            GET1: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE:   w_state_nxt = CAPT;
            CAPT:    w_state_nxt = HOLD;
            HOLD: begin
                if (bus.res_ready) begin
                    w_state_nxt = GET0;
                end
            end
            default: w_state_nxt = GET0;
        endcase
    end

    assign w_accept = w_in_ready & bus.in_valid;
    assign w_res_hs = r_res_valid & bus.res_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op0       <= '0;
            r_op1       <= '0;
            r_last_flag <= 1'b0;
            r_res_data  <= '0;
            r_res_last  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_accept && (r_state == GET0)) begin
                r_op0 <= bus.in_data;
                if (bus.in_last) begin
                    r_op1       <= '0;
                    r_last_flag <= 1'b1;
                end
            end
            if (w_accept && (r_state == GET1)) begin
                r_op1       <= bus.in_data;
                r_last_flag <= bus.in_last;
            end
            // The adder registered op0+op1 on the edge leaving ISSUE.
            if (r_state == CAPT) begin
                r_res_data  <= bus.sum_in;
                r_res_last  <= r_last_flag;
                r_res_valid <= 1'b1;
            end
            if ((r_state == HOLD) && w_res_hs) begin
                r_res_valid <= 1'b0;
            end
        end
    end

`ifdef PAIR_SUM_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            pair_cnt <= '0;
        end else if (w_res_hs) begin
            pair_cnt <= pair_cnt + 1'b1;
        end
    end
`endif

    // Held low during reset so nothing is taken until reset deasserts.
    assign bus.in_ready  = w_in_ready & ~reset;
    assign bus.op0       = r_op0;
    assign bus.op1       = r_op1;
    assign bus.res_data  = r_res_data;
    assign bus.res_last  = r_res_last;
    assign bus.res_valid = r_res_valid;

endmodule : pair_sum_initiator

`default_nettype wire

// File: tb/tb_pair_sum_initiator.sv
// ============================================================================
//  Module      : tb_pair_sum_initiator
//  Description : Self-checking bench: pair initiator plus registered adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pair_sum_initiator;

    logic clock;
    logic reset;

    pair_sum_initiator_if #(.DATA_W(8)) bus ();

`ifdef PAIR_SUM_STATS_EN
    logic [15:0] pair_cnt;
`endif

    pair_sum_initiator #(.DATA_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus)
`ifdef PAIR_SUM_STATS_EN
        , .pair_cnt (pair_cnt)
`endif
    );

    pair_sum_adder #(.DATA_W(8)) adder (
        .clock (clock),
        .reset (reset),
        .in0   (bus.op0),
        .in1   (bus.op1),
        .out   (bus.sum_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pairs accepted bytes and predicts each result.
    logic [8:0]  exp_q[$];
    logic [8:0]  got[$];
    logic [7:0]  first_byte;
    bit          have_first;
    bit          busy;
    bit          prev_valid;
    int          cyc;
    int          acc_cyc;
    int          lat;
    logic [15:0] model_cnt;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
            have_first = 1'b0;
            busy       = 1'b0;
            prev_valid = 1'b0;
            model_cnt  = '0;
        end else begin
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, !busy});
            if (bus.in_valid && bus.in_ready) begin
                if (have_first) begin
                    exp_q.push_back({1'b0, 8'((int'(first_byte) + int'(bus.in_data)) % 256)});
                    exp_q[exp_q.size()-1][8] = bus.in_last;
                    have_first = 1'b0;
                    busy       = 1'b1;
                    acc_cyc    = cyc;
                end else if (bus.in_last) begin
                    exp_q.push_back({1'b1, bus.in_data});
                    busy    = 1'b1;
                    acc_cyc = cyc;
                end else begin
                    first_byte = bus.in_data;
                    have_first = 1'b1;
                end
            end
            check("res_valid", {31'd0, bus.res_valid}, {31'd0, busy && (cyc - acc_cyc >= 3)});
            if (bus.res_valid && exp_q.size() > 0) begin
                check("res_data", {24'd0, bus.res_data}, {24'd0, exp_q[0][7:0]});
                check("res_last", {31'd0, bus.res_last}, {31'd0, exp_q[0][8]});
            end
            if (bus.res_valid && !prev_valid) lat = cyc - acc_cyc;
`ifdef PAIR_SUM_STATS_EN
            check("pair_cnt", {16'd0, pair_cnt}, {16'd0, model_cnt});
`endif
            if (bus.res_valid && bus.res_ready && exp_q.size() > 0) begin
                got.push_back({bus.res_last, bus.res_data});
                void'(exp_q.pop_front());
                busy      = 1'b0;
                model_cnt = model_cnt + 16'd1;
            end
            prev_valid = bus.res_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        @(negedge clock);
        while (!bus.in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (got.size() < n && k < 100) begin
            @(posedge clock);
            k++;
        end
        #1;
        check("result_count", got.size(), n);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b1;
        first_byte    = '0;
        acc_cyc       = 0;
        lat           = 0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_res_data",  {24'd0, bus.res_data},  32'd0);
        check("rst_res_last",  {31'd0, bus.res_last},  32'd0);
        check("rst_op0",       {24'd0, bus.op0},       32'd0);
        check("rst_op1",       {24'd0, bus.op1},       32'd0);
`ifdef PAIR_SUM_STATS_EN
        check("rst_pair_cnt",  {16'd0, pair_cnt},      32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clock);
        #1;

        // Basic pair and its latency
        got.delete();
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        wait_results(1);
        if (got.size() >= 1) check("t1_sum", {23'd0, got[0]}, 32'h046);
        check("t1_latency", lat, 3);

        // Carry dropped
        got.delete();
        send(8'hFF, 1'b0);
        send(8'h01, 1'b0);
        wait_results(1);
        if (got.size() >= 1) check("t2_wrap", {23'd0, got[0]}, 32'h000);

        // Odd burst: tail paired with zero and flagged last
        got.delete();
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b1);
        wait_results(2);
        if (got.size() >= 2) begin
            check("t3_first",  {23'd0, got[0]}, 32'h00B);
            check("t3_tail",   {23'd0, got[1]}, 32'h107);
        end

        // Back-pressure hold
        got.delete();
        bus.res_ready = 1'b0;
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        repeat (10) @(negedge clock);
        check("t4_hold_valid", {31'd0, bus.res_valid}, 32'd1);
        check("t4_hold_data",  {24'd0, bus.res_data},  32'h46);
        check("t4_in_ready",   {31'd0, bus.in_ready},  32'd0);
        @(posedge clock);
        #1;
        bus.res_ready = 1'b1;
        wait_results(1);
        if (got.size() >= 1) check("t4_sum", {23'd0, got[0]}, 32'h046);

        // Reset discards a half-collected pair
        got.delete();
        send(8'h20, 1'b0);
        pulse_reset();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        wait_results(1);
        if (got.size() >= 1) check("t5_after_reset", {23'd0, got[0]}, 32'h003);

`ifdef PAIR_SUM_STATS_EN
        // Counter with irregular consumer readiness
        pulse_reset();
        got.delete();
        for (int i = 0; i < 4; i++) begin
            bus.res_ready = 1'($urandom_range(0, 1));
            send(8'(i + 1), 1'b0);
            send(8'(i * 3), 1'b0);
            repeat ($urandom_range(0, 4)) @(posedge clock);
            #1;
            bus.res_ready = 1'b1;
            wait_results(i + 1);
        end
        @(negedge clock);
        check("t6_pair_cnt", {16'd0, pair_cnt}, 32'd4);
        @(posedge clock);
        #1;
        pulse_reset();
        @(negedge clock);
        check("t6_cnt_cleared", {16'd0, pair_cnt}, 32'd0);
`endif

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pair_sum_initiator

`default_nettype wire
